router_ctrl: RTL and testbench

//  Control unit of the 1x3 router: Moore FSM sequencing the byte register stage (header hold, load, full-hold, parity).

---
 rtl/router_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_router_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/router_ctrl.sv
// -----------------------------------------------------------------------------
// router_ctrl
// Control unit of the 1x3 packet router. A Moore FSM sequences the byte
// register stage (header hold, payload load, full-hold, parity). It latches
// the destination address from the header byte and steers the write enable
// to one of three output FIFOs. Each output port has its own timeout
// counter. If a port shows valid data that is not read for TIMEOUT cycles,
// that port receives a one-cycle soft_reset flush pulse.
//
// Optional feature (macro ROUTER_ADDR_CHECK_EN):
//   defined   - a header with address 3 moves the FSM to DROP. Bytes are
//               discarded until pkt_valid falls.
//   undefined - address 3 is ignored. The FSM stays in DA and re-decodes
//               each following byte as a header candidate.
//
// Parameters:
//   TIMEOUT  unread-valid cycles before soft_reset pulses (default 30)
//   CW       width of each timeout counter, 2**CW >= TIMEOUT
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst            synchronous reset, active-low
//   pkt_valid      packet-valid from the source
//   data_in[1:0]   address field of the header byte
//   parity_done    parity byte captured (from register stage)
//   low_pkt_valid  packet ended while the FSM was held (from register stage)
//   full[2:0]      per-FIFO full flags
//   empty[2:0]     per-FIFO empty flags
//   read_enb[2:0]  per-port read strobes from the destinations
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                  state strobes to the register stage
//   write_enb_reg  byte-write qualifier
//   busy           back-pressure to the source
//   fifo_full      full flag of the currently addressed FIFO
//   write_enb[2:0] one-hot FIFO write enable
//   vld_out[2:0]   per-port data valid (the inverse of empty)
//   soft_reset[2:0] registered one-cycle per-FIFO flush pulse
// -----------------------------------------------------------------------------
module router_ctrl #(
   parameter int TIMEOUT = 30,
   parameter int CW      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   input  logic [2:0] full,
   input  logic [2:0] empty,
   input  logic [2:0] read_enb,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       write_enb_reg,
   output logic       busy,
   output logic       fifo_full,
   output logic [2:0] write_enb,
   output logic [2:0] vld_out,
   output logic [2:0] soft_reset
);

   typedef enum logic [3:0] {
      S_DA  = 4'd0,
      S_LFD = 4'd1,
      S_LD  = 4'd2,
      S_FFS = 4'd3,
      S_LAF = 4'd4,
      S_LP  = 4'd5,
      S_CPE = 4'd6,
      S_WTE = 4'd7
`ifdef ROUTER_ADDR_CHECK_EN
      ,S_DROP = 4'd8
`endif
   } state_t;

   state_t     state_reg, state_next;
   logic [1:0] addr_reg;

   // The vectors are padded to 4 bits so that a 2-bit address can index any
   // code without an out-of-range select. Address 3 then reads as 0.
   logic [3:0] full_pad, empty_pad, soft_pad;

   assign full_pad  = {1'b0, full};
   assign empty_pad = {1'b0, empty};
   assign soft_pad  = {1'b0, soft_reset};

   assign vld_out   = ~empty;
   assign fifo_full = full_pad[addr_reg];
   assign write_enb = write_enb_reg ? (3'b001 << addr_reg) : 3'b000;

   // ------------------------------------------------------------------
   // State and address registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= S_DA;
         addr_reg  <= 2'd0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_DA && pkt_valid && data_in != 2'b11)
            addr_reg <= data_in;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_DA: begin
            if (pkt_valid && data_in != 2'b11)
               state_next = empty_pad[data_in] ? S_LFD : S_WTE;
`ifdef ROUTER_ADDR_CHECK_EN
            else if (pkt_valid)
               state_next = S_DROP;
`endif
         end
         S_LFD: state_next = S_LD;
         S_LD: begin
            // If full and the end of the packet arrive together, full wins.
            if (fifo_full)
               state_next = S_FFS;
            else if (!pkt_valid)
               state_next = S_LP;
         end
         S_FFS: if (!fifo_full) state_next = S_LAF;
         S_LAF: begin
            if (parity_done)
               state_next = S_DA;
            else if (low_pkt_valid)
               state_next = S_LP;
            else
               state_next = S_LD;
         end
         S_LP:  state_next = S_CPE;
         S_CPE: state_next = fifo_full ? S_FFS : S_DA;
         S_WTE: if (empty_pad[addr_reg]) state_next = S_LFD;
`ifdef ROUTER_ADDR_CHECK_EN
         S_DROP: if (!pkt_valid) state_next = S_DA;
`endif
         default: state_next = S_DA;
      endcase

      // A flush of the FIFO this packet targets aborts the packet.
      if (state_reg != S_DA && soft_pad[addr_reg])
         state_next = S_DA;
   end

   // ------------------------------------------------------------------
   // Moore output decode
   // ------------------------------------------------------------------
   always_comb begin
      detect_add    = (state_reg == S_DA);
      lfd_state     = (state_reg == S_LFD);
      ld_state      = (state_reg == S_LD);
      laf_state     = (state_reg == S_LAF);
      full_state    = (state_reg == S_FFS);
      rst_int_reg   = (state_reg == S_CPE);
      write_enb_reg = (state_reg == S_LD) || (state_reg == S_LAF) ||
                      (state_reg == S_LP);
      busy          = (state_reg == S_LFD) || (state_reg == S_FFS) ||
                      (state_reg == S_LAF) || (state_reg == S_LP)  ||
                      (state_reg == S_CPE) || (state_reg == S_WTE);
   end

   // ------------------------------------------------------------------
   // Per-port read timeout
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_timeout
         logic [CW-1:0] cnt_reg;
         logic          soft_reg;

         always_ff @(posedge clk) begin
            if (!rst) begin
               cnt_reg  <= '0;
               soft_reg <= 1'b0;
            end else if (!vld_out[gi] || read_enb[gi]) begin
               // A read on the terminal-count cycle also suppresses the pulse.
               cnt_reg  <= '0;
               soft_reg <= 1'b0;
            end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
               cnt_reg  <= '0;
               soft_reg <= 1'b1;
            end else begin
               cnt_reg  <= cnt_reg + 1'b1;
               soft_reg <= 1'b0;
            end
         end

         assign soft_reset[gi] = soft_reg;
      end
   endgenerate

endmodule

// File: tb/tb_router_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_ctrl
// Directed testbench for router_ctrl. The FSM state is recovered from the
// output strobes and compared against hand-computed sequences. The bench
// also checks the write enables, busy, fifo_full and soft_reset.
// Expectations for the address-3 case follow ROUTER_ADDR_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_router_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       parity_done;
   logic       low_pkt_valid;
   logic [2:0] full;
   logic [2:0] empty;
   logic [2:0] read_enb;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       rst_int_reg, write_enb_reg, busy, fifo_full;
   logic [2:0] write_enb, vld_out, soft_reset;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int C_DA   = 0;
   localparam int C_LFD  = 1;
   localparam int C_LD   = 2;
   localparam int C_FFS  = 3;
   localparam int C_LAF  = 4;
   localparam int C_LP   = 5;
   localparam int C_CPE  = 6;
   localparam int C_WTE  = 7;
   localparam int C_NONE = 8;   // no strobe and not busy (DROP)
   localparam int C_BAD  = 9;   // the strobes do not match any state

   always #5 clk = ~clk;

   router_ctrl #(.TIMEOUT(30), .CW(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .full          (full),
      .empty         (empty),
      .read_enb      (read_enb),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .write_enb_reg (write_enb_reg),
      .busy          (busy),
      .fifo_full     (fifo_full),
      .write_enb     (write_enb),
      .vld_out       (vld_out),
      .soft_reset    (soft_reset)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Recover the state from the strobes. Exactly one pattern is legal per state.
   function automatic int state_code();
      int n;
      n = int'(detect_add) + int'(lfd_state) + int'(ld_state) +
          int'(laf_state) + int'(full_state) + int'(rst_int_reg);
      if (n > 1)                                 return C_BAD;
      if (detect_add)                            return busy ? C_BAD : C_DA;
      if (lfd_state)                             return C_LFD;
      if (ld_state)                              return C_LD;
      if (laf_state)                             return C_LAF;
      if (full_state)                            return C_FFS;
      if (rst_int_reg)                           return C_CPE;
      if (write_enb_reg && busy)                 return C_LP;
      if (!write_enb_reg && busy)                return C_WTE;
      if (!write_enb_reg && !busy)               return C_NONE;
      return C_BAD;
   endfunction

   // Advance one cycle and sample 1 ns after the active edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_state(input string tag, input int exp_st,
                            input logic [2:0] exp_we, input logic exp_busy);
      check_eq({tag, ".state"}, state_code(), exp_st);
      check_eq({tag, ".write_enb"}, {29'd0, write_enb}, {29'd0, exp_we});
      check_eq({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
   endtask

   initial begin
      rst = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
      low_pkt_valid = 1'b0; full = 3'b000; empty = 3'b111; read_enb = 3'b000;

      // ---- reset state ----
      step(1);
      rst = 1'b1;
      chk_state("reset", C_DA, 3'b000, 1'b0);
      check_eq("reset.soft_reset", {29'd0, soft_reset}, 32'd0);
      check_eq("reset.vld_out", {29'd0, vld_out}, 32'd0);

      // ---- 1: port 1, one payload byte, then parity ----
      pkt_valid = 1'b1; data_in = 2'b01;
      step(1); chk_state("t1.lfd", C_LFD, 3'b000, 1'b1);
      data_in = 2'b10;
      step(1); chk_state("t1.ld0", C_LD, 3'b010, 1'b0);
      step(1); chk_state("t1.ld1", C_LD, 3'b010, 1'b0);
      pkt_valid = 1'b0;
      step(1); chk_state("t1.lp", C_LP, 3'b010, 1'b1);
      step(1); chk_state("t1.cpe", C_CPE, 3'b000, 1'b1);
      step(1); chk_state("t1.da", C_DA, 3'b000, 1'b0);

      // ---- 2: port 2 not empty -> wait till empty ----
      empty = 3'b011; pkt_valid = 1'b1; data_in = 2'b10;
      step(1); chk_state("t2.wte0", C_WTE, 3'b000, 1'b1);
      check_eq("t2.vld_out", {29'd0, vld_out}, 32'h4);
      step(2); chk_state("t2.wte2", C_WTE, 3'b000, 1'b1);
      empty = 3'b111;
      step(1); chk_state("t2.lfd", C_LFD, 3'b000, 1'b1);
      step(1); chk_state("t2.ld", C_LD, 3'b100, 1'b0);
      pkt_valid = 1'b0;
      step(1); chk_state("t2.lp", C_LP, 3'b100, 1'b1);
      step(1); chk_state("t2.cpe", C_CPE, 3'b000, 1'b1);
      step(1); chk_state("t2.da", C_DA, 3'b000, 1'b0);

      // ---- 3: port 0, full during LD, together with the end of packet ----
      pkt_valid = 1'b1; data_in = 2'b00;
      step(1); chk_state("t3.lfd", C_LFD, 3'b000, 1'b1);
      step(1); chk_state("t3.ld", C_LD, 3'b001, 1'b0);
      full = 3'b001; pkt_valid = 1'b0;
      step(1); chk_state("t3.ffs", C_FFS, 3'b000, 1'b1);
      check_eq("t3.fifo_full", {31'd0, fifo_full}, 32'd1);
      step(1); chk_state("t3.ffs_hold", C_FFS, 3'b000, 1'b1);
      full = 3'b000;
      step(1); chk_state("t3.laf", C_LAF, 3'b001, 1'b1);
      step(1); chk_state("t3.ld2", C_LD, 3'b001, 1'b0);
      step(1); chk_state("t3.lp", C_LP, 3'b001, 1'b1);
      step(1); chk_state("t3.cpe", C_CPE, 3'b000, 1'b1);
      step(1); chk_state("t3.da", C_DA, 3'b000, 1'b0);

      // ---- 4: timeout on port 0 ----
      empty = 3'b110; read_enb = 3'b000;
      step(29); check_eq("t4.soft_29", {29'd0, soft_reset}, 32'd0);
      step(1);  check_eq("t4.soft_30", {29'd0, soft_reset}, 32'd1);
      step(1);  check_eq("t4.soft_31", {29'd0, soft_reset}, 32'd0);
      // The counter restarted after the pulse. A read at cycle 29 restarts it again.
      step(27);
      read_enb = 3'b001;
      step(1);
      read_enb = 3'b000;
      step(29); check_eq("t4.restart_29", {29'd0, soft_reset}, 32'd0);
      step(1);  check_eq("t4.restart_30", {29'd0, soft_reset}, 32'd1);
      // Packet latched on port 0 in LD, then port 0 times out.
      empty = 3'b111; pkt_valid = 1'b1; data_in = 2'b00;
      step(1); chk_state("t4.lfd", C_LFD, 3'b000, 1'b1);
      step(1); chk_state("t4.ld", C_LD, 3'b001, 1'b0);
      empty = 3'b110;
      step(29); check_eq("t4.ld_soft_29", {29'd0, soft_reset}, 32'd0);
      step(1);  check_eq("t4.ld_soft_30", {29'd0, soft_reset}, 32'd1);
      chk_state("t4.ld_hold", C_LD, 3'b001, 1'b0);
      step(1);  chk_state("t4.abort", C_DA, 3'b000, 1'b0);
      pkt_valid = 1'b0; empty = 3'b111;
      step(1);

      // ---- 5: reset during LD ----
      pkt_valid = 1'b1; data_in = 2'b01;
      step(1); chk_state("t5.lfd", C_LFD, 3'b000, 1'b1);
      step(1); chk_state("t5.ld", C_LD, 3'b010, 1'b0);
      empty = 3'b110;
      step(20);
      rst = 1'b0;
      step(1);
      rst = 1'b1; pkt_valid = 1'b0;
      chk_state("t5.rst", C_DA, 3'b000, 1'b0);
      check_eq("t5.soft", {29'd0, soft_reset}, 32'd0);
      // The counter was cleared, so a full 30 cycles are needed again.
      step(29); check_eq("t5.cnt_29", {29'd0, soft_reset}, 32'd0);
      step(1);  check_eq("t5.cnt_30", {29'd0, soft_reset}, 32'd1);
      empty = 3'b111;
      step(1);

      // ---- 6: header address 3 ----
      pkt_valid = 1'b1; data_in = 2'b11;
      for (int i = 0; i < 4; i++) begin
         step(1);
`ifdef ROUTER_ADDR_CHECK_EN
         chk_state($sformatf("t6.drop%0d", i), C_NONE, 3'b000, 1'b0);
`else
         chk_state($sformatf("t6.da%0d", i), C_DA, 3'b000, 1'b0);
`endif
      end
      pkt_valid = 1'b0;
      step(1); chk_state("t6.da_end", C_DA, 3'b000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
